ahb_slv_resp_mux: RTL and testbench

Data-phase response stage directly downstream of the address decoder. It latches the decoder's slave selection (hreq, default_slv_sel) at each address-phase boundary and routes the selected slave's hreadyout, hresp and hrdata back to the bus master in the following data phase. It also contains the built-in default slave, which answers unmapped accesses with the two-cycle AHB ERROR response and keeps a saturating error counter for debug.

---
 rtl/ahb_slv_resp_mux.sv | 150 +++++++++++++++
 tb/tb_ahb_slv_resp_mux.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slv_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_slv_resp_mux
//
// Data-phase response stage that sits behind the AHB address decoder.
// At every address-phase boundary (hready = 1) it latches which slave was
// selected. In the following data phase it routes that slave's
// hreadyout / hresp / hrdata back to the master. The multiplexing is
// combinational from the slave inputs, so it adds no latency.
//
// It also contains the default slave. Any NONSEQ or SEQ access to an
// unmapped address gets the two-cycle AHB ERROR response from it. A
// saturating counter records how many ERROR responses it has issued.
//
// Ports
//   hclk             bus clock, rising-edge active
//   hreset_n         asynchronous active-low reset
//   hreq             one-hot slave request from the decoder (address phase)
//   default_slv_sel  unmapped-address flag from the decoder (address phase)
//   htrans           transfer type: IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   hreadyout_slv    per-slave ready
//   hresp_slv        per-slave response, slave i at [2i+1:2i]
//   hrdata_slv       per-slave read data, slave i at slice i
//   hready           bus ready; also the internal address-phase enable
//   hresp            bus response: OKAY=00 ERROR=01 RETRY=10 SPLIT=11
//   hrdata           bus read data
//   dflt_err_cnt     number of ERROR responses issued by the default slave
// ---------------------------------------------------------------------------
module ahb_slv_resp_mux #(
    parameter int MASTER_X_SLAVE_NUM = 7,
    parameter int AHB_DATA_WIDTH     = 32,
    parameter int ERR_CNT_WIDTH      = 8
) (
    input  logic                                     hclk,
    input  logic                                     hreset_n,
    input  logic [MASTER_X_SLAVE_NUM-1:0]            hreq,
    input  logic                                     default_slv_sel,
    input  logic [1:0]                               htrans,
    input  logic [MASTER_X_SLAVE_NUM-1:0]            hreadyout_slv,
    input  logic [2*MASTER_X_SLAVE_NUM-1:0]          hresp_slv,
    input  logic [AHB_DATA_WIDTH*MASTER_X_SLAVE_NUM-1:0] hrdata_slv,
    output logic                                     hready,
    output logic [1:0]                               hresp,
    output logic [AHB_DATA_WIDTH-1:0]                hrdata,
    output logic [ERR_CNT_WIDTH-1:0]                 dflt_err_cnt
);

    localparam int IDX_W = (MASTER_X_SLAVE_NUM > 1) ? $clog2(MASTER_X_SLAVE_NUM) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Default-slave FSM encoding
    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic [1:0]       ds_state;
    logic [1:0]       ds_state_nxt;

    logic             sel_vld_nxt;
    logic [IDX_W-1:0] sel_idx_nxt;
    logic             dflt_act;

    // ------------------------------------------------------------------
    // Address-phase decode: lowest set hreq bit wins. Any hreq bit
    // overrides default_slv_sel, and IDLE/BUSY never start an error.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        sel_idx_nxt = '0;
        for (int i = MASTER_X_SLAVE_NUM - 1; i >= 0; i--) begin
            if (hreq[i]) begin
                sel_idx_nxt = i[IDX_W-1:0];
            end
        end
        sel_vld_nxt = |hreq;
        dflt_act    = default_slv_sel & ~(|hreq) & htrans[1];
    end

    // Selection registers only move at an address-phase boundary.
    always_ff @(posedge hclk or negedge hreset_n) begin
        // NOTE: sequential state uses non-blocking assignments so that
        // every register samples the values from before the edge.
        if (!hreset_n) begin
            sel_vld <= 1'b0;
            sel_idx <= '0;
        end else if (hready) begin
            sel_vld <= sel_vld_nxt;
            sel_idx <= sel_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Default slave. DS_ERR1 holds hready low, so it advances on its own
    // without a sample. DS_ERR2 drives hready high, so the next address
    // is sampled there. That is what lets errors run back to back, and
    // it also lets a master that drops to IDLE cancel cleanly.
    // ------------------------------------------------------------------
    always_comb begin
        ds_state_nxt = ds_state;
        case (ds_state)
            DS_IDLE: if (hready && dflt_act) ds_state_nxt = DS_ERR1;
            DS_ERR1: ds_state_nxt = DS_ERR2;
            DS_ERR2: if (hready) ds_state_nxt = dflt_act ? DS_ERR1 : DS_IDLE;
            default: ds_state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            ds_state     <= DS_IDLE;
            dflt_err_cnt <= '0;
        end else begin
            ds_state <= ds_state_nxt;
            // Every entry into DS_ERR1 is one ERROR response; saturate.
            if (ds_state_nxt == DS_ERR1 && dflt_err_cnt != {ERR_CNT_WIDTH{1'b1}}) begin
                dflt_err_cnt <= dflt_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Data-phase output mux. An out-of-range sel_idx matches no slave and
    // falls through to the idle response.
    // ------------------------------------------------------------------
    always_comb begin
        hready = 1'b1;
        hresp  = RESP_OKAY;
        hrdata = '0;
        if (sel_vld) begin
            for (int i = 0; i < MASTER_X_SLAVE_NUM; i++) begin
                if (sel_idx == i[IDX_W-1:0]) begin
                    hready = hreadyout_slv[i];
                    hresp  = hresp_slv[2*i +: 2];
                    hrdata = hrdata_slv[AHB_DATA_WIDTH*i +: AHB_DATA_WIDTH];
                end
            end
        end else if (ds_state == DS_ERR1) begin
            hready = 1'b0;
            hresp  = RESP_ERROR;
        end else if (ds_state == DS_ERR2) begin
            hready = 1'b1;
            hresp  = RESP_ERROR;
        end
    end

endmodule

// File: tb/tb_ahb_slv_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_slv_resp_mux
//
// Directed bench for ahb_slv_resp_mux. Inputs change on the falling edge.
// Outputs are observed 1 ns later, well away from the rising sampling edge.
// ---------------------------------------------------------------------------
module tb_ahb_slv_resp_mux;

    localparam int N  = 7;
    localparam int DW = 32;
    localparam int CW = 8;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic              hclk;
    logic              hreset_n;
    logic [N-1:0]      hreq;
    logic              default_slv_sel;
    logic [1:0]        htrans;
    logic [N-1:0]      hreadyout_slv;
    logic [2*N-1:0]    hresp_slv;
    logic [DW*N-1:0]   hrdata_slv;
    logic              hready;
    logic [1:0]        hresp;
    logic [DW-1:0]     hrdata;
    logic [CW-1:0]     dflt_err_cnt;

    int checks = 0;
    int errors = 0;

    ahb_slv_resp_mux #(
        .MASTER_X_SLAVE_NUM(N),
        .AHB_DATA_WIDTH    (DW),
        .ERR_CNT_WIDTH     (CW)
    ) dut (
        .hclk           (hclk),
        .hreset_n       (hreset_n),
        .hreq           (hreq),
        .default_slv_sel(default_slv_sel),
        .htrans         (htrans),
        .hreadyout_slv  (hreadyout_slv),
        .hresp_slv      (hresp_slv),
        .hrdata_slv     (hrdata_slv),
        .hready         (hready),
        .hresp          (hresp),
        .hrdata         (hrdata),
        .dflt_err_cnt   (dflt_err_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // All slaves ready/OKAY with filler data; no address request.
    task automatic drive_idle();
        hreq            = '0;
        default_slv_sel = 1'b0;
        htrans          = T_IDLE;
        hreadyout_slv   = '1;
        hresp_slv       = '0;
        for (int i = 0; i < N; i++) hrdata_slv[DW*i +: DW] = 32'hFFFF_FFFF;
    endtask

    task automatic drive_unmapped(input logic [1:0] tr);
        hreq            = '0;
        default_slv_sel = 1'b1;
        htrans          = tr;
    endtask

    task automatic next_cycle();
        @(negedge hclk);
    endtask

    task automatic chk_bus(input string name, input logic exp_rdy, input logic [1:0] exp_resp);
        #1;
        checks++;
        if (hready !== exp_rdy || hresp !== exp_resp) begin
            errors++;
            $display("FAIL %s: hready=%b hresp=%b, expected hready=%b hresp=%b",
                     name, hready, hresp, exp_rdy, exp_resp);
        end
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        drive_idle();
        repeat (3) next_cycle();
        #1;
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0 || dflt_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_in: hready=%b hresp=%b hrdata=%h cnt=%0d, expected 1 00 0 0",
                     hready, hresp, hrdata, dflt_err_cnt);
        end
        hreset_n = 1'b1;
        repeat (3) next_cycle();
        #1;
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0 || dflt_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: hready=%b hresp=%b hrdata=%h cnt=%0d, expected 1 00 0 0",
                     hready, hresp, hrdata, dflt_err_cnt);
        end
    endtask

    task automatic test_slave_wait();
        next_cycle();
        hreq   = 7'b0000100;
        htrans = T_NONSEQ;
        hrdata_slv[DW*2 +: DW] = 32'h0;
        next_cycle();
        drive_idle();
        hreadyout_slv[2] = 1'b0;
        hrdata_slv[DW*2 +: DW] = 32'h0;
        chk_bus("slv2_wait1", 1'b0, 2'b00);
        next_cycle();
        chk_bus("slv2_wait2", 1'b0, 2'b00);
        next_cycle();
        hreadyout_slv[2] = 1'b1;
        hrdata_slv[DW*2 +: DW] = 32'hA5A5_0002;
        chk_bus("slv2_done", 1'b1, 2'b00);
        checks++;
        if (hrdata !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL slv2_data: got %h expected a5a50002", hrdata);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_default_error();
        drive_unmapped(T_NONSEQ);
        next_cycle();
        drive_idle();
        chk_bus("err_cycle1", 1'b0, 2'b01);
        next_cycle();
        chk_bus("err_cycle2", 1'b1, 2'b01);
        next_cycle();
        chk_bus("err_after", 1'b1, 2'b00);
        checks++;
        if (dflt_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_cnt_1: got %0d expected 1", dflt_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive_unmapped(T_NONSEQ);
        next_cycle();                       // DS_ERR1
        drive_idle();
        chk_bus("b2b_a_err1", 1'b0, 2'b01);
        next_cycle();                       // DS_ERR2, sample slave 0
        hreq   = 7'b0000001;
        htrans = T_NONSEQ;
        chk_bus("b2b_a_err2", 1'b1, 2'b01);
        next_cycle();                       // slave 0 data; next address unmapped
        drive_idle();
        hrdata_slv[0 +: DW] = 32'h1234_5678;
        drive_unmapped(T_NONSEQ);
        chk_bus("after_err_slv0", 1'b1, 2'b00);
        checks++;
        if (hrdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL after_err_data: got %h expected 12345678", hrdata);
        end
        next_cycle();                       // DS_ERR1 (count 3)
        drive_idle();
        chk_bus("b2b_b_err1", 1'b0, 2'b01);
        next_cycle();                       // DS_ERR2, sample another unmapped
        drive_unmapped(T_NONSEQ);
        chk_bus("b2b_b_err2", 1'b1, 2'b01);
        next_cycle();                       // DS_ERR1 (count 4)
        drive_idle();
        chk_bus("b2b_c_err1", 1'b0, 2'b01);
        next_cycle();
        chk_bus("b2b_c_err2", 1'b1, 2'b01);
        next_cycle();
        chk_bus("b2b_idle", 1'b1, 2'b00);
        checks++;
        if (dflt_err_cnt !== 8'd4) begin
            errors++;
            $display("FAIL err_cnt_4: got %0d expected 4", dflt_err_cnt);
        end
    endtask

    task automatic test_corners();
        hreq   = 7'b0000101;
        htrans = T_NONSEQ;
        hrdata_slv[0 +: DW]      = 32'h0000_AAAA;
        hrdata_slv[DW*2 +: DW]   = 32'h2222_2222;
        next_cycle();                       // data phase of multi-hot request
        drive_unmapped(T_BUSY);
        hrdata_slv[0 +: DW]      = 32'h0000_AAAA;
        hrdata_slv[DW*2 +: DW]   = 32'h2222_2222;
        #1;
        checks++;
        if (hrdata !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL prio_slv0: got %h expected 0000aaaa", hrdata);
        end
        next_cycle();                       // BUSY to unmapped sampled
        hreq            = 7'b0001000;
        default_slv_sel = 1'b0;
        htrans          = T_NONSEQ;
        #1;
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0 || dflt_err_cnt !== 8'd4) begin
            errors++;
            $display("FAIL busy_unmapped: hready=%b hresp=%b hrdata=%h cnt=%0d, expected 1 00 0 4",
                     hready, hresp, hrdata, dflt_err_cnt);
        end
        next_cycle();                       // slave 3 SPLIT, first cycle
        drive_idle();
        hreadyout_slv[3]  = 1'b0;
        hresp_slv[7:6]    = 2'b11;
        chk_bus("split_1", 1'b0, 2'b11);
        next_cycle();
        hreadyout_slv[3]  = 1'b1;
        chk_bus("split_2", 1'b1, 2'b11);
        next_cycle();
        drive_idle();
    endtask

    task automatic test_async_reset();
        drive_unmapped(T_NONSEQ);
        next_cycle();
        drive_idle();
        chk_bus("rst_pre_err1", 1'b0, 2'b01);
        #1;
        hreset_n = 1'b0;                    // mid-cycle, no clock edge
        #1;
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00 || dflt_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: hready=%b hresp=%b cnt=%0d, expected 1 00 0",
                     hready, hresp, dflt_err_cnt);
        end
        next_cycle();
        hreset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_saturation();
        drive_unmapped(T_NONSEQ);
        repeat (10) next_cycle();           // 10 rising edges -> 5 errors
        #1;
        checks++;
        if (dflt_err_cnt !== 8'd5) begin
            errors++;
            $display("FAIL cnt_ramp: got %0d expected 5", dflt_err_cnt);
        end
        repeat (590) next_cycle();          // 600 edges total -> 300 errors
        #1;
        checks++;
        if (dflt_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d expected 255", dflt_err_cnt);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_slave_wait();
        test_default_error();
        test_back_to_back();
        test_corners();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
